vga_rx_monitor: RTL
===================

Name: vga_rx_monitor

Overview:
- Receiving end of the game's VGA output. Consumes hsync/vsync/RGB as driven at the top-level pins and recovers the pixel grid.
- Locks to 640x480@60 timing, flags timing and blanking violations, and reports per-frame pixel statistics.
- Used in simulation benches and as an on-chip self-check tap on the VGA pins; clocked by the same 25.175 MHz pixel clock.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- H_BACK_START, 144, hpos of first visible pixel (sync 96 + back porch 48)
- V_VISIBLE, 480, visible lines
- V_TOTAL, 525, lines per frame
- V_BACK_START, 35, vpos of first visible line (sync 2 + back porch 33)
- SYNC_ACTIVE_LOW, 1, sync polarity (1 = active low)
- MATCH_COLOR, 12'h070, colour counted by the optional match counter

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active high
- hsync_i  in  1  horizontal sync from VGA source
- vsync_i  in  1  vertical sync from VGA source
- red_i / green_i / blue_i  in  4 each  pixel colour
- locked_o  out  1  timing lock achieved
- pixel_valid_o  out  1  current sample is a visible pixel while locked
- position_x_o  out  10  visible x (0..639), 0 when not valid
- position_y_o  out  10  visible y (0..479), 0 when not valid
- frame_done_o  out  1  one-cycle pulse; stats below are valid from this cycle
- frame_sum_o  out  32  sum of {r,g,b} as 12-bit unsigned over all visible pixels of the last frame
- match_count_o  out  19  visible pixels equal to MATCH_COLOR in the last frame
- frame_count_o  out  16  completed locked frames, wraps at 2^16
- error_o  out  1  one-cycle pulse on loss of lock
- error_count_o  out  8  loss-of-lock events, saturates at 255
- blank_err_o  out  1  sticky; nonzero RGB seen during blanking while locked

Behaviour:
- Stage 1 registers all inputs. Sync signals are normalised to active-high before any use.
- h_edge: stage-1 hsync active and previously inactive.
- hpos: 0 on an h_edge sample, otherwise previous + 1, saturating at 1023.
- vpos: updates only on h_edge.
  - Goes to 0 if vsync is active at this h_edge and was inactive at the previous h_edge (frame start, f_edge).
  - Otherwise previous + 1, saturating at 1023.
- Line check, on every h_edge: the previous sample's hpos must equal H_TOTAL-1.
- Frame check, on every f_edge: vpos before the update must equal V_TOTAL-1.
- Visible sample: hpos in [H_BACK_START, H_BACK_START+H_VISIBLE) and vpos in [V_BACK_START, V_BACK_START+V_VISIBLE).
- FSM states:
  - SEARCH (reset state): go to ALIGN on the first f_edge.
  - ALIGN: a line check failure returns to SEARCH with no error pulse. At the next f_edge, frame check pass -> LOCKED; fail -> stay in ALIGN.
  - LOCKED: any line or frame check failure -> SEARCH, pulse error_o, increment error_count_o. If a check fails on the same edge as a frame end, the failure wins and no frame_done_o is issued.
- Frame statistics:
  - Accumulators clear on entry to LOCKED and at every LOCKED f_edge.
  - They accumulate only on visible samples while LOCKED.
  - At a LOCKED f_edge whose frame check passes: copy the accumulators to frame_sum_o / match_count_o, increment frame_count_o, pulse frame_done_o.
  - The completed frame ends at that edge; the first frame after lock begins at the locking edge.
- Latency: locked_o, pixel_valid_o, position_x_o, position_y_o, frame_done_o and error_o are registered. They describe the pin sample from 2 clocks earlier.
- Blank check: while LOCKED, any non-visible sample with RGB != 0 sets blank_err_o. It stays set until reset.
- Reset values: every output 0 and the FSM in SEARCH. Reset mid-frame discards partial statistics. Lock then requires a full alignment frame again.

Optional Feature:
- Macro: VGA_RX_MATCH_EN.
- Defined: MATCH_COLOR comparator and 19-bit counter are built; match_count_o behaves as above.
- Undefined: no comparator or counter logic; match_count_o is tied to 0.

Test Plan:
- Ideal 640x480 source, all pixels 12'h000 -> locked_o rises at the second f_edge (+2 clk). Each later frame pulses frame_done_o with frame_sum_o=0. frame_count_o increments 1,2,3.
- Locked, solid 12'hfb5 visible area -> frame_sum_o = 32'h49A07000. match_count_o = 0.
- Locked, MATCH_COLOR 12'h070 in a 40x50 box on a black field -> match_count_o = 2000 with VGA_RX_MATCH_EN defined, 0 without it. frame_sum_o = 2000*0x070 = 224000.
- Locked, one line shortened to 799 clocks -> single error_o pulse, error_count_o=1, locked_o=0. No frame_done_o for that frame. Relock after two further good frame starts.
- Locked, pixel 12'h001 driven at hpos 10 of any line -> blank_err_o=1 and stays 1 through following frames until rst_i.
- rst_i asserted for 1 clk mid-frame while locked -> next cycle all outputs 0. The next f_edge enters ALIGN only; lock waits for the following f_edge.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers the VGA pixel grid from sync/RGB pins, checks timing and blanking, reports per-frame stats
// Ports: clk_i, rst_i (sync, active high); hsync_i, vsync_i, red_i, green_i, blue_i from the VGA source;
//   locked_o, pixel_valid_o, position_x_o, position_y_o, frame_done_o, frame_sum_o, match_count_o,
//   frame_count_o, error_o, error_count_o, blank_err_o. Per-sample outputs trail the pins by 2 clocks.
// Option: define VGA_RX_MATCH_EN to build the MATCH_COLOR counter; otherwise match_count_o is tied to 0.
module vga_rx_monitor #(
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL = 800,
  parameter int H_BACK_START = 144,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL = 525,
  parameter int V_BACK_START = 35,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [11:0] MATCH_COLOR = 12'h070
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic        locked_o,
  output logic        pixel_valid_o,
  output logic [9:0]  position_x_o,
  output logic [9:0]  position_y_o,
  output logic        frame_done_o,
  output logic [31:0] frame_sum_o,
  output logic [18:0] match_count_o,
  output logic [15:0] frame_count_o,
  output logic        error_o,
  output logic [7:0]  error_count_o,
  output logic        blank_err_o
);
  localparam logic [9:0] HB = 10'(H_BACK_START);
  localparam logic [9:0] HE = 10'(H_BACK_START + H_VISIBLE);
  localparam logic [9:0] VB = 10'(V_BACK_START);
  localparam logic [9:0] VE = 10'(V_BACK_START + V_VISIBLE);
  localparam logic [9:0] HL = 10'(H_TOTAL - 1);
  localparam logic [9:0] VL = 10'(V_TOTAL - 1);
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;
  state_t state, state_nx;
  logic hs1, vs1, hs_d, vs_h;
  logic [11:0] rgb1;
  logic [9:0] hpos_q, vpos_q, hpos, vpos;
  logic h_edge, f_edge, line_ok, frame_ok, vis, lk, fail, done;
  logic [31:0] acc;
  // vs_h holds vsync as seen at the previous h_edge, so a frame starts only on its first sync line
  always_comb begin
    h_edge = hs1 & ~hs_d;
    f_edge = h_edge & vs1 & ~vs_h;
    hpos = h_edge ? '0 : (&hpos_q ? hpos_q : hpos_q + 10'd1);
    vpos = f_edge ? '0 : (h_edge && !(&vpos_q)) ? vpos_q + 10'd1 : vpos_q;
    line_ok = hpos_q == HL;
    frame_ok = vpos_q == VL;
    vis = hpos >= HB && hpos < HE && vpos >= VB && vpos < VE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= SEARCH;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == SEARCH ? (f_edge ? ALIGN : SEARCH)
             : state == ALIGN ? (h_edge && !line_ok ? SEARCH : (f_edge && frame_ok) ? LOCKED : ALIGN)
             : fail ? SEARCH : LOCKED;
  end
  // a failed check on a frame-end edge suppresses that frame's done pulse
  always_comb begin
    lk = state == LOCKED;
    fail = h_edge & (~line_ok | (f_edge & ~frame_ok));
    done = lk & f_edge & ~fail;
    locked_o = lk;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      hs_d <= 1'b0;
      vs_h <= 1'b0;
      rgb1 <= '0;
      hpos_q <= '0;
      vpos_q <= '0;
      acc <= '0;
      pixel_valid_o <= 1'b0;
      position_x_o <= '0;
      position_y_o <= '0;
      frame_done_o <= 1'b0;
      frame_sum_o <= '0;
      frame_count_o <= '0;
      error_o <= 1'b0;
      error_count_o <= '0;
      blank_err_o <= 1'b0;
    end else begin
      hs1 <= hsync_i ^ SYNC_ACTIVE_LOW;
      vs1 <= vsync_i ^ SYNC_ACTIVE_LOW;
      rgb1 <= {red_i, green_i, blue_i};
      hs_d <= hs1;
      vs_h <= h_edge ? vs1 : vs_h;
      hpos_q <= hpos;
      vpos_q <= vpos;
      acc <= f_edge ? '0 : (lk && vis) ? acc + 32'(rgb1) : acc;
      pixel_valid_o <= lk & vis;
      position_x_o <= (lk && vis) ? hpos - HB : '0;
      position_y_o <= (lk && vis) ? vpos - VB : '0;
      frame_done_o <= done;
      frame_sum_o <= done ? acc : frame_sum_o;
      frame_count_o <= done ? frame_count_o + 16'd1 : frame_count_o;
      error_o <= lk & fail;
      error_count_o <= (lk && fail && !(&error_count_o)) ? error_count_o + 8'd1 : error_count_o;
      blank_err_o <= blank_err_o | (lk & ~vis & (|rgb1));
    end
  end
`ifdef VGA_RX_MATCH_EN
  logic [18:0] mcnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcnt <= '0;
      match_count_o <= '0;
    end else begin
      mcnt <= f_edge ? '0 : (lk && vis && rgb1 == MATCH_COLOR) ? mcnt + 19'd1 : mcnt;
      match_count_o <= done ? mcnt : match_count_o;
    end
  end
`else
  logic unused_match;
  assign unused_match = ^MATCH_COLOR;
  assign match_count_o = '0;
`endif
endmodule
